// File: rtl/dsp_mem_loader_pkg.sv
// dsp_mem_loader_pkg
//   Shared definitions for the DSP-unit burst loader: FSM state type,
//   header field positions and the burst-length extraction helper.
//   Header word layout (low 32 bits):
//     [31:20]           burst length - 1 (1..4096 data words)
//     [ADDR_WIDTH-1:0]  start address = unit sel | cmd(0)/wave(1) | 12b address
package dsp_mem_loader_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } loader_state_t;

    localparam int HDR_LEN_LSB = 20;
    localparam int HDR_LEN_W   = 12;
    localparam int WAVE_ADDR_W = 12;

    // Burst length minus one, taken straight from the header word.
    function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [31:0] word);
        return word[HDR_LEN_LSB +: HDR_LEN_W];
    endfunction

endpackage

// File: rtl/dsp_mem_loader.sv
// dsp_mem_loader
//   Converts a valid/ready word stream into the single-word write bus of the
//   DSP-unit bank. A header word selects unit, region and start address; the
//   following N data words are written to consecutive addresses (low 12 bits
//   wrap inside the region).
//
//   Optional feature: define DSP_MEM_LOADER_CHECKSUM_EN to add the `checksum`
//   output (sum of the data words of the most recent completed burst).
//
// Ports
//   clk             in   sole clock
//   reset           in   asynchronous, active-low reset
//   s_data          in   header or data word
//   s_valid         in   word present
//   s_ready         out  word accepted when s_valid & s_ready
//   abort           in   synchronous burst cancel
//   mem_write_addr  out  write address (unit sel | cmd/wave | 12b addr)
//   mem_write_data  out  write data
//   mem_write_en    out  one-cycle write strobe
//   busy            out  a burst is in progress
//   done            out  pulses with the write of the final data word
//   err_unit        out  sticky: header selected a non-existent unit
//   err_wrap        out  sticky: burst crossed the 12b address boundary
//   checksum        out  (DSP_MEM_LOADER_CHECKSUM_EN only) last burst data sum
import dsp_mem_loader_pkg::*;

module dsp_mem_loader #(
    parameter  int DATA_WIDTH = 32,
    parameter  int N_DSP_UNIT = 2,
    localparam int ADDR_WIDTH = 13 + $clog2(N_DSP_UNIT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err_unit,
`ifdef DSP_MEM_LOADER_CHECKSUM_EN
    output logic                  err_wrap,
    output logic [DATA_WIDTH-1:0] checksum
`else
    output logic                  err_wrap
`endif
);

    localparam int UNIT_LSB = WAVE_ADDR_W + 1;

    loader_state_t state_q, state_d;

    logic hs;
    logic capture;
    logic word_fire;
    logic last_word;

    logic [ADDR_WIDTH-1:0] hdr_addr;
    logic [31:0]           hdr_unit;
    logic                  hdr_bad_unit;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [HDR_LEN_W-1:0]  remain_q, remain_d;
    logic                  bad_unit_q, bad_unit_d;
    logic                  first_q, first_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  done_q, done_d;
    logic                  err_unit_q, err_unit_d;
    logic                  err_wrap_q, err_wrap_d;
`ifdef DSP_MEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
`endif

    // The loader only stalls while in reset or while a cancel is requested,
    // so an aborted cycle never consumes a word.
    assign s_ready = reset & ~abort;
    assign hs      = s_valid & s_ready;

    assign hdr_addr     = s_data[ADDR_WIDTH-1:0];
    assign hdr_unit     = 32'(hdr_addr) >> UNIT_LSB;
    assign hdr_bad_unit = (hdr_unit >= 32'(N_DSP_UNIT));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (hs) state_d = BURST;
                BURST:   if (hs && remain_q == '0) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs / control strobes ----------------
    always_comb begin
        capture   = 1'b0;
        word_fire = 1'b0;
        last_word = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                capture = hs;
            end
            BURST: begin
                busy      = 1'b1;
                word_fire = hs;
                last_word = hs && (remain_q == '0);
            end
            default: ;
        endcase
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        addr_d     = addr_q;
        remain_d   = remain_q;
        bad_unit_d = bad_unit_q;
        first_d    = first_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        done_d     = 1'b0;
        err_unit_d = err_unit_q;
        err_wrap_d = err_wrap_q;
`ifdef DSP_MEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        checksum_d = checksum_q;
`endif
        if (abort) begin
            remain_d = '0;
        end else if (capture) begin
            addr_d     = hdr_addr;
            remain_d   = hdr_len(s_data[31:0]);
            bad_unit_d = hdr_bad_unit;
            first_d    = 1'b1;
            err_unit_d = hdr_bad_unit;
            err_wrap_d = 1'b0;
`ifdef DSP_MEM_LOADER_CHECKSUM_EN
            sum_d      = '0;
`endif
        end else if (word_fire) begin
            wr_addr_d = addr_q;
            wr_data_d = s_data;
            // A non-existent unit still consumes its data; only the strobe is
            // suppressed.
            wr_en_d   = ~bad_unit_q;
            done_d    = last_word;
            first_d   = 1'b0;
            addr_d    = {addr_q[ADDR_WIDTH-1:WAVE_ADDR_W],
                         addr_q[WAVE_ADDR_W-1:0] + WAVE_ADDR_W'(1)};
            // Writing low address 0 anywhere but the first word means the
            // previous word was at 0xFFF, i.e. the burst wrapped.
            if (!first_q && addr_q[WAVE_ADDR_W-1:0] == '0) begin
                err_wrap_d = 1'b1;
            end
            if (!last_word) begin
                remain_d = remain_q - HDR_LEN_W'(1);
            end
`ifdef DSP_MEM_LOADER_CHECKSUM_EN
            sum_d = sum_q + s_data;
            if (last_word) begin
                checksum_d = sum_q + s_data;
            end
`endif
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            remain_q   <= '0;
            bad_unit_q <= 1'b0;
            first_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            err_unit_q <= 1'b0;
            err_wrap_q <= 1'b0;
`ifdef DSP_MEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            checksum_q <= '0;
`endif
        end else begin
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            bad_unit_q <= bad_unit_d;
            first_q    <= first_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            done_q     <= done_d;
            err_unit_q <= err_unit_d;
            err_wrap_q <= err_wrap_d;
`ifdef DSP_MEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            checksum_q <= checksum_d;
`endif
        end
    end

    assign mem_write_addr = wr_addr_q;
    assign mem_write_data = wr_data_q;
    assign mem_write_en   = wr_en_q;
    assign done           = done_q;
    assign err_unit       = err_unit_q;
    assign err_wrap       = err_wrap_q;
`ifdef DSP_MEM_LOADER_CHECKSUM_EN
    assign checksum       = checksum_q;
`endif

endmodule

// File: tb/tb_dsp_mem_loader.sv
// tb_dsp_mem_loader
//   Drives directed and randomized bursts into dsp_mem_loader (3 DSP units,
//   15-bit address) and compares every cycle against expectations computed
//   from burst parameters: address = region | (start + i) mod 4096, strobe
//   only for existing units, done on the last word, sticky error flags and
//   the running data sum.
module tb_dsp_mem_loader;

    localparam int DW = 32;
    localparam int NU = 3;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          abort = 1'b0;
    logic [AW-1:0] mem_write_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_write_en;
    logic          busy;
    logic          done;
    logic          err_unit;
    logic          err_wrap;
    logic [DW-1:0] checksum;

    dsp_mem_loader #(
        .DATA_WIDTH(DW),
        .N_DSP_UNIT(NU)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .abort          (abort),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .busy           (busy),
        .done           (done),
        .err_unit       (err_unit),
`ifdef DSP_MEM_LOADER_CHECKSUM_EN
        .err_wrap       (err_wrap),
        .checksum       (checksum)
`else
        .err_wrap       (err_wrap)
`endif
    );

`ifndef DSP_MEM_LOADER_CHECKSUM_EN
    assign checksum = '0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic        exp_err_unit = 1'b0;
    logic        exp_err_wrap = 1'b0;
    logic [31:0] exp_checksum = '0;
    logic [31:0] burst_data[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_en"},   mem_write_en, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        s_valid = 1'b0;
        abort   = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("idle");
        check("idle_err_unit", err_unit, exp_err_unit);
        check("idle_err_wrap", err_wrap, exp_err_wrap);
    endtask

    // One burst: header then burst_data, optional gaps, optional abort at
    // word index abort_at (-1 = none). Leaves the bus right after the last edge.
    task automatic run_burst(input string name, input int unit, input bit wave,
                             input int start, input int abort_at, input bit gaps);
        int          n;
        int          writes;
        bit          bad;
        logic [31:0] hdr;
        logic [31:0] sum;
        logic [14:0] exp_addr;
        n      = burst_data.size();
        writes = 0;
        sum    = '0;
        bad    = (unit >= NU);
        hdr    = 32'((n - 1) << 20) | 32'($urandom_range(0, 31) << 15)
               | 32'(unit << 13) | (32'(wave) << 12) | 32'(start);

        @(negedge clk);
        abort   = 1'b0;
        s_valid = 1'b1;
        s_data  = hdr;
        #1 check("hdr_ready", s_ready, 1'b1);
        @(posedge clk); #1;
        exp_err_unit = bad;
        exp_err_wrap = 1'b0;
        check("hdr_en", mem_write_en, 1'b0);
        check("hdr_busy", busy, 1'b1);
        check("hdr_done", done, 1'b0);
        check("hdr_err_unit", err_unit, exp_err_unit);
        check("hdr_err_wrap", err_wrap, 1'b0);

        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
                check("gap_en", mem_write_en, 1'b0);
                check("gap_busy", busy, 1'b1);
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = burst_data[i];
            if (i == abort_at) begin
                abort = 1'b1;
                #1 check("abort_ready", s_ready, 1'b0);
                @(posedge clk); #1;
                check("abort_en", mem_write_en, 1'b0);
                check("abort_done", done, 1'b0);
                check("abort_busy", busy, 1'b0);
                check("abort_err_unit", err_unit, exp_err_unit);
                check("abort_err_wrap", err_wrap, exp_err_wrap);
`ifdef DSP_MEM_LOADER_CHECKSUM_EN
                check("abort_checksum", checksum, exp_checksum);
`endif
                @(negedge clk);
                abort   = 1'b0;
                s_valid = 1'b0;
                $display("burst %s unit=%0d start=%03h words=%0d writes=%0d aborted_at=%0d",
                         name, unit, start, n, writes, i);
                return;
            end
            @(posedge clk); #1;
            exp_addr = 15'((unit << 13) | (int'(wave) << 12) | ((start + i) % 4096));
            if (start + i >= 4096) exp_err_wrap = 1'b1;
            sum = sum + burst_data[i];
            check("wr_en", mem_write_en, !bad);
            if (!bad) begin
                writes++;
                check("wr_addr", mem_write_addr, exp_addr);
                check("wr_data", mem_write_data, burst_data[i]);
            end
            check("wr_done", done, i == n - 1);
            check("wr_busy", busy, i != n - 1);
            check("wr_err_wrap", err_wrap, exp_err_wrap);
            check("wr_err_unit", err_unit, exp_err_unit);
            if (i == n - 1) begin
                exp_checksum = sum;
`ifdef DSP_MEM_LOADER_CHECKSUM_EN
                check("checksum", checksum, exp_checksum);
`endif
            end
        end
        $display("burst %s unit=%0d start=%03h words=%0d writes=%0d sum=%08h",
                 name, unit, start, n, writes, sum);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", s_ready, 1'b0);
        check("rst_addr", mem_write_addr, '0);
        check("rst_data", mem_write_data, '0);
        check_idle_outputs("rst");
        check("rst_err_unit", err_unit, 1'b0);
        check("rst_err_wrap", err_wrap, 1'b0);
        check("rst_checksum", checksum, '0);
        @(negedge clk);
        reset = 1'b1;
        idle_cycle();

        // basic burst
        burst_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        run_burst("basic", 1, 1'b1, 12'h010, -1, 1'b0);
        idle_cycle();

        // wrap, followed back-to-back by a second burst
        burst_data = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_burst("wrap", 0, 1'b0, 12'hFFE, -1, 1'b0);
        burst_data = '{32'h5555_0001, 32'h5555_0002, 32'h5555_0003};
        run_burst("b2b", 2, 1'b1, 12'h7A0, -1, 1'b0);
        idle_cycle();

        // bad unit
        burst_data = '{32'hDEAD_0001, 32'hDEAD_0002};
        run_burst("bad_unit", 3, 1'b0, 12'h020, -1, 1'b0);
        idle_cycle();

        // abort on the 2nd of 5 words, then a normal burst
        burst_data = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        run_burst("abort", 1, 1'b0, 12'h100, 1, 1'b0);
        idle_cycle();
        burst_data = '{32'h9};
        run_burst("after_abort", 0, 1'b1, 12'h000, -1, 1'b0);

        // checksum rollover
        burst_data = '{32'hFFFF_FFFF, 32'h0000_0002};
        run_burst("checksum", 2, 1'b0, 12'h300, -1, 1'b0);
        check("checksum_model", exp_checksum, 32'h1);
        idle_cycle();

        // randomized bursts
        for (int k = 0; k < 25; k++) begin
            int unit;
            int start;
            int n;
            int ab;
            unit  = $urandom_range(0, 3);
            start = ($urandom_range(0, 2) == 0) ? 4096 - $urandom_range(1, 8)
                                               : $urandom_range(0, 4095);
            n     = $urandom_range(1, 12);
            ab    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            burst_data = {};
            for (int j = 0; j < n; j++) burst_data.push_back($urandom());
            run_burst($sformatf("rand%0d", k), unit, 1'($urandom_range(0, 1)),
                      start, ab, 1'b1);
            if ($urandom_range(0, 1) == 0 || ab >= 0) idle_cycle();
        end

        // asynchronous reset in the middle of a burst with a write pending
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 32'h0050_2123;   // 6 words, unit 1, cmd, addr 0x123
        @(negedge clk);
        s_data  = 32'hCAFE_0000;
        @(posedge clk); #1;
        check("pre_rst_en", mem_write_en, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_en", mem_write_en, 1'b0);
        check("mid_rst_addr", mem_write_addr, '0);
        check("mid_rst_data", mem_write_data, '0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_err_unit", err_unit, 1'b0);
        check("mid_rst_err_wrap", err_wrap, 1'b0);
        check("mid_rst_checksum", checksum, '0);
        check("mid_rst_ready", s_ready, 1'b0);
        exp_err_unit = 1'b0;
        exp_err_wrap = 1'b0;
        exp_checksum = '0;
        $display("reset mid-burst applied");
        @(negedge clk);
        s_valid = 1'b0;
        reset   = 1'b1;
        idle_cycle();
        burst_data = '{32'h77, 32'h88};
        run_burst("post_reset", 0, 1'b0, 12'h0F0, -1, 1'b0);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dsp_mem_loader.md
# dsp_mem_loader

Burst loader sitting directly upstream of the DSP-unit bank. It converts a valid/ready word stream from the host interface into the single-word `mem_write_addr`/`mem_write_data`/`mem_write_en` write bus that the bank decodes: one header word selects unit, region and start address, then N data words are written to consecutive addresses. The write bus output drives every DSP unit directly. Each unit gates its own enable on the unit-select bits.

## Interface
- `DATA_WIDTH`, 32: stream and write data width; must be ≥ 32.
- `N_DSP_UNIT`, 2: number of DSP units; 1..8.
- `ADDR_WIDTH` (localparam): 13+$clog2(N_DSP_UNIT). Layout: unit sel | 1b cmd(0)/wave(1) | 12b address.

- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-low reset.
- `s_data`  in  DATA_WIDTH  header or data word.
- `s_valid`  in  1  word present.
- `s_ready`  out  1  word accepted when `s_valid & s_ready`.
- `abort`  in  1  synchronous burst cancel.
- `mem_write_addr`  out  ADDR_WIDTH  write address.
- `mem_write_data`  out  DATA_WIDTH  write data.
- `mem_write_en`  out  1  one-cycle write strobe.
- `busy`  out  1  state is BURST.
- `done`  out  1  one-cycle pulse after the last data word is written.
- `err_unit`  out  1  sticky flag: header unit sel ≥ N_DSP_UNIT.
- `err_wrap`  out  1  sticky flag: burst crossed the 12b address boundary.

## Operation
- Header word fields:
  - `[ADDR_WIDTH-1:0]`: start address.
  - `[31:20]`: burst length − 1, giving 1..4096 data words.
  - Remaining bits are ignored.
- States:
  - IDLE: a handshake captures the header and moves to BURST. Nothing is written.
  - BURST: each handshake issues one write at the current address, then the low 12 address bits increment. The upper bits (unit sel, cmd/wave) are held constant.
  - On the final word (remaining count = 0), go to IDLE and pulse `done` together with that word's write.
- Address wrap: 0xFFF increments to 0x000 within the same region, and `err_wrap` is set. Writes continue.
- Unit sel ≥ N_DSP_UNIT:
  - `err_unit` is set at header capture.
  - Data words are still consumed and the counter runs.
  - `mem_write_en` is held 0 for the whole burst. `done` still pulses.
- `s_ready` = reset deasserted & ~`abort`. The loader never back-pressures otherwise.
- `abort` in any state:
  - Next state is IDLE and the counter is cleared.
  - The same-cycle word is not accepted, so no write is issued.
  - `done` does not pulse. Error flags are kept.
- Error flags clear only on reset or on the next header capture.

## Timing
- Reset values: `mem_write_addr`=0, `mem_write_data`=0, `mem_write_en`=0, `busy`=0, `done`=0, `err_*`=0. State is IDLE.
- Write outputs are registered. A handshake at edge t produces `mem_write_en` high during cycle t+1. Address and data are stable with it.
- `mem_write_addr`/`mem_write_data` hold their last value when `mem_write_en`=0.
- Throughput is one data word per cycle with no bubbles. A header may be accepted in the cycle immediately after the final data word.
- `busy` rises the cycle after header capture. It falls the cycle after the final-word handshake or abort.
- Reset mid-burst: all outputs return to reset values immediately (asynchronous). Any pending write is dropped.

## Configuration
- `DSP_MEM_LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` [DATA_WIDTH-1:0] (reset 0).
  - It holds the modulo-2^DATA_WIDTH sum of all data words of the most recent completed burst (header excluded).
  - It updates in the same cycle `done` pulses. Aborted bursts leave it unchanged.
- Macro undefined: no port, no accumulator logic.

## Structure
- Package `dsp_mem_loader_pkg` holds:
  - the state enum `loader_state_t` (IDLE, BURST);
  - header field offsets/widths (`HDR_LEN_LSB`=20, `HDR_LEN_W`=12, `WAVE_ADDR_W`=12);
  - a `hdr_len` extraction function.
- Single flat module. No sub-module is needed.

## Test plan
- Basic burst:
  - Stimulus: header unit 1, wave, addr 0x010, length field 3 (4 words); data A0..A3 back-to-back.
  - Required: writes at addresses {1,1,0x010}..{1,1,0x013}, each one cycle after its handshake; `done` with the last write; `busy` low next cycle.
- Wrap:
  - Stimulus: header addr 0xFFE, 4 words.
  - Required: addresses 0xFFE, 0xFFF, 0x000, 0x001 (region bits unchanged); `err_wrap`=1 from the third write.
- Bad unit:
  - Stimulus: N_DSP_UNIT=2, header unit sel 3 (needs ADDR_WIDTH ≥ 15 variant, N_DSP_UNIT=3), 2 words.
  - Required: both words accepted, `mem_write_en` never high, `err_unit`=1, `done` pulses.
- Abort:
  - Stimulus: abort asserted together with `s_valid` on the 2nd of 5 data words.
  - Required: that word is not accepted; only 1 write issued; no `done`; next header is accepted normally.
- Back-to-back:
  - Stimulus: header H2 presented the cycle after the final data word of burst 1.
  - Required: H2 captured with no idle gap and burst 2 writes correct.
  - Also: asynchronous reset asserted mid-burst clears all outputs within the same cycle.
- Checksum (macro defined):
  - Stimulus: data 0xFFFFFFFF, 0x00000002.
  - Required: `checksum`=0x00000001 at `done`.
